// File: rtl/branch_pkg.sv
// Shared branch definitions: condition codes used by the comparator, decoder and
// redirect controller, plus the redirect FSM state encoding.
package branch_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_JUMP = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_HOLD     = 2'd2,
    ST_EXC      = 2'd3
  } redir_state_e;

  // Jumps are unconditional; every other code (including undefined 011) follows the comparator.
  function automatic logic br_is_taken(input logic [2:0] code, input logic cmp_taken);
    return cmp_taken | (code == BR_JUMP);
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// EX-stage resolution bus into the redirect controller and the PC/flush/exception
// results it returns to the pipeline.
interface branch_redirect_ctrl_if
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) ();

  // Handshake: a resolution is offered when EX_VALID=1 and PIPE_STALL=0 at a rising
  // edge; IMEM_BUSY=1 is fetch's not-ready, holding PC_SEL/PC_TARGET until it drops.
  logic             EX_VALID;
  logic [3:0]       BRANCH_SEL;
  logic             BRANCH_TAKEN;
  logic [XLEN-1:0]  BRANCH_TARGET;
  logic             PIPE_STALL;
  logic             IMEM_BUSY;

  logic             PC_SEL;
  logic [XLEN-1:0]  PC_TARGET;
  logic             FLUSH_IFID;
  logic             FLUSH_IDEX;
  logic             MISALIGN_EXC;
  logic [XLEN-1:0]  MISALIGN_ADDR;
  logic [CNT_W-1:0] TAKEN_CNT;
  redir_state_e     DBG_STATE;

  modport master (
    output EX_VALID, BRANCH_SEL, BRANCH_TAKEN, BRANCH_TARGET, PIPE_STALL, IMEM_BUSY,
    input  PC_SEL, PC_TARGET, FLUSH_IFID, FLUSH_IDEX, MISALIGN_EXC, MISALIGN_ADDR,
           TAKEN_CNT, DBG_STATE
  );

  modport slave (
    input  EX_VALID, BRANCH_SEL, BRANCH_TAKEN, BRANCH_TARGET, PIPE_STALL, IMEM_BUSY,
    output PC_SEL, PC_TARGET, FLUSH_IFID, FLUSH_IDEX, MISALIGN_EXC, MISALIGN_ADDR,
           TAKEN_CNT, DBG_STATE
  );

endinterface

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             INC,
  output logic [WIDTH-1:0] COUNT
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (INC && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign COUNT = count_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Post-EX branch redirect sequencer: drives PC redirect, IF/ID and ID/EX flushes,
// misaligned-target exceptions and a saturating taken-transfer count.
module branch_redirect_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int CNT_W          = 16,
  parameter int MISALIGN_CHECK = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  branch_redirect_ctrl_if.slave bus
);

  localparam logic CHECK_EN = (MISALIGN_CHECK != 0);

  redir_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_target_q, pc_target_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;
  logic            pc_sel_q, pc_sel_d;
  logic            flush_ifid_q, flush_ifid_d;
  logic            flush_idex_q, flush_idex_d;
  logic            misalign_exc_q, misalign_exc_d;
  logic            inc_taken;
  logic            res_evt, taken_evt, misalign_evt;
  logic [CNT_W-1:0] taken_cnt;

  assign res_evt      = bus.EX_VALID & bus.BRANCH_SEL[3] & ~bus.PIPE_STALL;
  assign taken_evt    = res_evt & br_is_taken(bus.BRANCH_SEL[2:0], bus.BRANCH_TAKEN);
  assign misalign_evt = taken_evt & CHECK_EN & (bus.BRANCH_TARGET[1:0] != 2'b00);

  always_comb begin
    state_d         = state_q;
    pc_target_d     = pc_target_q;
    misalign_addr_d = misalign_addr_q;
    inc_taken       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (misalign_evt) begin
          state_d         = ST_EXC;
          misalign_addr_d = bus.BRANCH_TARGET;
        end else if (taken_evt) begin
          state_d     = ST_REDIRECT;
          pc_target_d = bus.BRANCH_TARGET;
          inc_taken   = 1'b1;
        end
      end
      // Outside IDLE the EX instruction is wrong-path and being flushed, so it is ignored.
      ST_REDIRECT: state_d = bus.IMEM_BUSY ? ST_HOLD : ST_IDLE;
      ST_HOLD:     state_d = bus.IMEM_BUSY ? ST_HOLD : ST_IDLE;
      ST_EXC:      state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state and registered alongside it.
    pc_sel_d       = (state_d == ST_REDIRECT) || (state_d == ST_HOLD);
    flush_ifid_d   = (state_d != ST_IDLE);
    flush_idex_d   = (state_d == ST_REDIRECT) || (state_d == ST_EXC);
    misalign_exc_d = (state_d == ST_EXC);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q         <= ST_IDLE;
      pc_target_q     <= '0;
      misalign_addr_q <= '0;
      pc_sel_q        <= 1'b0;
      flush_ifid_q    <= 1'b0;
      flush_idex_q    <= 1'b0;
      misalign_exc_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_target_q     <= pc_target_d;
      misalign_addr_q <= misalign_addr_d;
      pc_sel_q        <= pc_sel_d;
      flush_ifid_q    <= flush_ifid_d;
      flush_idex_q    <= flush_idex_d;
      misalign_exc_q  <= misalign_exc_d;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_taken_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .INC   (inc_taken),
    .COUNT (taken_cnt)
  );

  assign bus.PC_SEL        = pc_sel_q;
  assign bus.PC_TARGET     = pc_target_q;
  assign bus.FLUSH_IFID    = flush_ifid_q;
  assign bus.FLUSH_IDEX    = flush_idex_q;
  assign bus.MISALIGN_EXC  = misalign_exc_q;
  assign bus.MISALIGN_ADDR = misalign_addr_q;
  assign bus.TAKEN_CNT     = taken_cnt;
  assign bus.DBG_STATE     = state_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: two instances (16-bit count with misalign check,
// 4-bit count without) share directed stimulus; each has its own expected queue.
module tb_branch_redirect_ctrl;
  import branch_pkg::*;

  localparam int W = 84;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [3:0]  branch_sel = 4'h0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        pipe_stall = 1'b0;
  logic        imem_busy = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];

  logic [31:0] pc_a = 0, ma_a = 0, pc_b = 0, ma_b = 0;
  logic [15:0] cnt_a = 0, cnt_b = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl_if #(.XLEN(32), .CNT_W(16)) bus_a ();
  branch_redirect_ctrl_if #(.XLEN(32), .CNT_W(4))  bus_b ();

  assign bus_a.EX_VALID      = ex_valid;
  assign bus_a.BRANCH_SEL    = branch_sel;
  assign bus_a.BRANCH_TAKEN  = branch_taken;
  assign bus_a.BRANCH_TARGET = branch_target;
  assign bus_a.PIPE_STALL    = pipe_stall;
  assign bus_a.IMEM_BUSY     = imem_busy;
  assign bus_b.EX_VALID      = ex_valid;
  assign bus_b.BRANCH_SEL    = branch_sel;
  assign bus_b.BRANCH_TAKEN  = branch_taken;
  assign bus_b.BRANCH_TARGET = branch_target;
  assign bus_b.PIPE_STALL    = pipe_stall;
  assign bus_b.IMEM_BUSY     = imem_busy;

  branch_redirect_ctrl #(.XLEN(32), .CNT_W(16), .MISALIGN_CHECK(1)) dut_a (
    .CLK(clk), .RESET(rst_n), .bus(bus_a.slave)
  );
  branch_redirect_ctrl #(.XLEN(32), .CNT_W(4), .MISALIGN_CHECK(0)) dut_b (
    .CLK(clk), .RESET(rst_n), .bus(bus_b.slave)
  );

  function automatic logic [W-1:0] rec(input logic pcs, input logic fi, input logic fx,
                                       input logic ex, input logic [31:0] pc,
                                       input logic [31:0] ma, input logic [15:0] cnt);
    return {pcs, fi, fx, ex, pc, ma, cnt};
  endfunction

  // Expected-response producers for each instance.
  task automatic exp_redirect_a(input logic [31:0] tgt);
    pc_a = tgt;
    if (cnt_a != 16'hFFFF) cnt_a = cnt_a + 16'd1;
    exp_a_q.push_back(rec(1, 1, 1, 0, pc_a, ma_a, cnt_a));
  endtask
  task automatic exp_hold_a();
    exp_a_q.push_back(rec(1, 1, 0, 0, pc_a, ma_a, cnt_a));
  endtask
  task automatic exp_exc_a(input logic [31:0] tgt);
    ma_a = tgt;
    exp_a_q.push_back(rec(0, 1, 1, 1, pc_a, ma_a, cnt_a));
  endtask
  task automatic exp_redirect_b(input logic [31:0] tgt);
    pc_b = tgt;
    if (cnt_b != 16'd15) cnt_b = cnt_b + 16'd1;
    exp_b_q.push_back(rec(1, 1, 1, 0, pc_b, ma_b, cnt_b));
  endtask
  task automatic exp_hold_b();
    exp_b_q.push_back(rec(1, 1, 0, 0, pc_b, ma_b, cnt_b));
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Monitor: whenever either instance drives any control output, pop and compare.
  initial begin
    logic [W-1:0] got_a, got_b, want;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        got_a = {bus_a.PC_SEL, bus_a.FLUSH_IFID, bus_a.FLUSH_IDEX, bus_a.MISALIGN_EXC,
                 bus_a.PC_TARGET, bus_a.MISALIGN_ADDR, bus_a.TAKEN_CNT};
        got_b = {bus_b.PC_SEL, bus_b.FLUSH_IFID, bus_b.FLUSH_IDEX, bus_b.MISALIGN_EXC,
                 bus_b.PC_TARGET, bus_b.MISALIGN_ADDR, 12'h000, bus_b.TAKEN_CNT};
        if (|got_a[W-1:W-4]) begin
          checks++;
          if (exp_a_q.size() == 0) begin
            errors++;
            $display("FAIL a_unexpected_output: got %h, required no activity", got_a);
          end else begin
            want = exp_a_q.pop_front();
            if (got_a !== want) begin
              errors++;
              $display("FAIL a_output: got %h, required %h", got_a, want);
            end
          end
        end
        if (|got_b[W-1:W-4]) begin
          checks++;
          if (exp_b_q.size() == 0) begin
            errors++;
            $display("FAIL b_unexpected_output: got %h, required no activity", got_b);
          end else begin
            want = exp_b_q.pop_front();
            if (got_b !== want) begin
              errors++;
              $display("FAIL b_output: got %h, required %h", got_b, want);
            end
          end
        end
      end
    end
  end

  // Present one resolution; optionally stall before sampling, hold fetch busy after,
  // and offer a wrong-path branch while the redirect is outstanding.
  task automatic drive_branch(input logic [3:0] sel, input logic tk, input logic [31:0] tgt,
                              input int stall_n, input int busy_n, input logic hold_br);
    ex_valid = 1'b1;
    branch_sel = sel;
    branch_taken = tk;
    branch_target = tgt;
    pipe_stall = (stall_n > 0);
    repeat (stall_n) begin @(posedge clk); #1; end
    pipe_stall = 1'b0;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    branch_taken = 1'b0;
    imem_busy = (busy_n > 0);
    if (hold_br) begin
      ex_valid = 1'b1;
      branch_sel = 4'b1000;
      branch_taken = 1'b1;
      branch_target = 32'h0000_0300;
    end
    repeat (busy_n) begin @(posedge clk); #1; end
    ex_valid = 1'b0;
    imem_busy = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc_sel_a"}, 32'(bus_a.PC_SEL), 32'd0);
    chk({tag, "_flush_ifid_a"}, 32'(bus_a.FLUSH_IFID), 32'd0);
    chk({tag, "_flush_idex_a"}, 32'(bus_a.FLUSH_IDEX), 32'd0);
    chk({tag, "_exc_a"}, 32'(bus_a.MISALIGN_EXC), 32'd0);
    chk({tag, "_pc_target_a"}, bus_a.PC_TARGET, 32'd0);
    chk({tag, "_misalign_addr_a"}, bus_a.MISALIGN_ADDR, 32'd0);
    chk({tag, "_cnt_a"}, 32'(bus_a.TAKEN_CNT), 32'd0);
    chk({tag, "_state_a"}, 32'(bus_a.DBG_STATE), 32'(ST_IDLE));
    chk({tag, "_pc_sel_b"}, 32'(bus_b.PC_SEL), 32'd0);
    chk({tag, "_cnt_b"}, 32'(bus_b.TAKEN_CNT), 32'd0);
    chk({tag, "_state_b"}, 32'(bus_b.DBG_STATE), 32'(ST_IDLE));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // BEQ taken, fetch ready: single redirect cycle.
    exp_redirect_a(32'h0000_0100);
    exp_redirect_b(32'h0000_0100);
    drive_branch(4'b1000, 1'b1, 32'h0000_0100, 0, 0, 1'b0);

    // BNE not taken: no activity, count unchanged.
    drive_branch(4'b1001, 1'b0, 32'h0000_0180, 0, 0, 1'b0);
    chk("cnt_after_bne_a", 32'(bus_a.TAKEN_CNT), 32'd1);
    chk("cnt_after_bne_b", 32'(bus_b.TAKEN_CNT), 32'd1);

    // JAL with comparator low, fetch busy 3 cycles, wrong-path branch during HOLD.
    exp_redirect_a(32'h0000_0200);
    exp_redirect_b(32'h0000_0200);
    repeat (3) begin exp_hold_a(); exp_hold_b(); end
    drive_branch(4'b1010, 1'b0, 32'h0000_0200, 0, 3, 1'b1);
    chk("cnt_after_jal_a", 32'(bus_a.TAKEN_CNT), 32'd2);
    chk("state_after_jal_a", 32'(bus_a.DBG_STATE), 32'(ST_IDLE));

    // BLT to 0x102: exception on the checked instance, plain redirect on the other.
    exp_exc_a(32'h0000_0102);
    exp_redirect_b(32'h0000_0102);
    drive_branch(4'b1100, 1'b1, 32'h0000_0102, 0, 0, 1'b0);
    chk("misalign_addr_held_a", bus_a.MISALIGN_ADDR, 32'h0000_0102);
    chk("cnt_after_exc_a", 32'(bus_a.TAKEN_CNT), 32'd2);
    chk("cnt_after_exc_b", 32'(bus_b.TAKEN_CNT), 32'd3);

    // BGE taken held by a 2-cycle stall: exactly one redirect and one count.
    exp_redirect_a(32'h0000_0400);
    exp_redirect_b(32'h0000_0400);
    drive_branch(4'b1101, 1'b1, 32'h0000_0400, 2, 0, 1'b0);
    chk("cnt_after_stall_a", 32'(bus_a.TAKEN_CNT), 32'd3);

    // Non-control op with comparator high, undefined code 011 not taken: no activity.
    drive_branch(4'b0000, 1'b1, 32'h0000_0440, 0, 0, 1'b0);
    drive_branch(4'b1011, 1'b0, 32'h0000_0444, 0, 0, 1'b0);
    // Undefined code 011 follows the comparator when it is high.
    exp_redirect_a(32'h0000_0450);
    exp_redirect_b(32'h0000_0450);
    drive_branch(4'b1011, 1'b1, 32'h0000_0450, 0, 0, 1'b0);
    chk("cnt_after_undef_a", 32'(bus_a.TAKEN_CNT), 32'd4);
    chk("cnt_after_undef_b", 32'(bus_b.TAKEN_CNT), 32'd5);

    // Reset asserted while in HOLD clears everything immediately.
    exp_redirect_a(32'h0000_0500);
    exp_redirect_b(32'h0000_0500);
    exp_hold_a();
    exp_hold_b();
    ex_valid = 1'b1;
    branch_sel = 4'b1010;
    branch_taken = 1'b0;
    branch_target = 32'h0000_0500;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    imem_busy = 1'b1;
    @(posedge clk); #1;
    chk("hold_state_a", 32'(bus_a.DBG_STATE), 32'(ST_HOLD));
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_state("mid_hold_reset");
    pc_a = 0; ma_a = 0; cnt_a = 0;
    pc_b = 0; ma_b = 0; cnt_b = 0;
    @(posedge clk); #1;
    imem_busy = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Sixteen taken branches: 16-bit count reaches 16, 4-bit count sticks at 15.
    for (int i = 0; i < 16; i++) begin
      exp_redirect_a(32'h0000_0600 + 32'(i * 4));
      exp_redirect_b(32'h0000_0600 + 32'(i * 4));
      drive_branch(4'b1000, 1'b1, 32'h0000_0600 + 32'(i * 4), 0, 0, 1'b0);
    end
    chk("sat_cnt_a", 32'(bus_a.TAKEN_CNT), 32'd16);
    chk("sat_cnt_b", 32'(bus_b.TAKEN_CNT), 32'd15);
    chk("exp_a_drained", 32'(exp_a_q.size()), 32'd0);
    chk("exp_b_drained", 32'(exp_b_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequencing controller that sits after the EX-stage branch comparator in the RV32IM pipeline. It samples the resolved branch/jump decision and drives the PC redirect and the IF/ID and ID/EX flushes. It holds a pending redirect while instruction fetch is busy and raises a misaligned-target exception instead of redirecting. It also keeps a saturating count of taken control transfers.

Parameters:
XLEN, 32, address/target width
CNT_W, 16, width of taken-transfer counter
MISALIGN_CHECK, 1, 1 = check target[1:0]; 0 = never raise misalign

Ports:
CLK  input  1  pipeline clock, rising edge
RESET  input  1  asynchronous, active-low reset
EX_VALID  input  1  EX stage holds a valid instruction
BRANCH_SEL  input  4  bit3 = control-transfer op; [2:0] = condition code (000 BEQ, 001 BNE, 010 JAL/JALR, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU)
BRANCH_TAKEN  input  1  comparator result for the EX instruction
BRANCH_TARGET  input  XLEN  computed target address
PIPE_STALL  input  1  EX held this cycle; no resolution accepted
IMEM_BUSY  input  1  fetch cannot accept a new PC this cycle
PC_SEL  output  1  1 = PC mux selects PC_TARGET
PC_TARGET  output  XLEN  registered redirect address
FLUSH_IFID  output  1  invalidate IF/ID on this edge
FLUSH_IDEX  output  1  invalidate ID/EX on this edge
MISALIGN_EXC  output  1  one-cycle misaligned-target exception pulse
MISALIGN_ADDR  output  XLEN  offending target, held until the next exception
TAKEN_CNT  output  CNT_W  saturating count of accepted taken transfers

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE. PC_SEL, FLUSH_IFID, FLUSH_IDEX and MISALIGN_EXC are 0. PC_TARGET, MISALIGN_ADDR and TAKEN_CNT are 0. Reset asserted mid-redirect abandons the pending redirect.
- Resolution event R = EX_VALID & BRANCH_SEL[3] & ~PIPE_STALL, sampled only in IDLE.
- Taken T = R & (BRANCH_TAKEN | BRANCH_SEL[2:0]==010). Code 010 forces taken regardless of BRANCH_TAKEN. Undefined codes 011 use BRANCH_TAKEN.
- Misaligned M = T & MISALIGN_CHECK & (BRANCH_TARGET[1:0]!=0).
- States: IDLE, REDIRECT, HOLD, EXC. All outputs are registered (Moore), so latency from the sampling edge to the outputs is 1 cycle.
- IDLE:
  - T&~M -> REDIRECT, latch PC_TARGET=BRANCH_TARGET, TAKEN_CNT+1 (saturates at all-ones).
  - M -> EXC, latch MISALIGN_ADDR, no count.
  - Otherwise stay in IDLE (not-taken, no-op, stall).
- REDIRECT (one cycle): PC_SEL=1, FLUSH_IFID=1, FLUSH_IDEX=1.
  - IMEM_BUSY=0 -> IDLE.
  - IMEM_BUSY=1 -> HOLD.
- HOLD: PC_SEL=1, FLUSH_IFID=1, FLUSH_IDEX=0, PC_TARGET stable. Stay while IMEM_BUSY=1; go to IDLE on the first cycle with IMEM_BUSY=0. No timeout.
- EXC (one cycle): MISALIGN_EXC=1, FLUSH_IFID=1, FLUSH_IDEX=1, PC_SEL=0 -> IDLE.
- In REDIRECT, HOLD and EXC, R events are ignored; EX contains a wrong-path instruction being flushed. They do not count and do not raise an exception.
- Back-to-back branches: the earliest a new event can be accepted is the first IDLE cycle after the redirect completes.
- PIPE_STALL=1 in IDLE suppresses R entirely. The same branch is re-sampled when the stall releases, so each branch is counted exactly once.
- PIPE_STALL does not affect REDIRECT, HOLD or EXC progression.
- Comparator output settles after #2. All sampling occurs at the clock edge only; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package branch_pkg holds:
  - the 3-bit condition-code constants (BR_BEQ, BR_BNE, BR_JUMP, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU), also used by the comparator and decoder;
  - the 2-bit state encoding for IDLE/REDIRECT/HOLD/EXC.
- One sub-module: sat_counter (parameter width; inputs CLK, RESET, INC; output COUNT; saturating; async active-low clear).

Test Plan:
- BEQ taken, BRANCH_SEL=1000, TAKEN=1, TARGET=0x0000_0100, IMEM_BUSY=0 -> next cycle PC_SEL=1, PC_TARGET=0x100, both flushes=1 for exactly 1 cycle; TAKEN_CNT=1.
- BNE not taken, BRANCH_SEL=1001, TAKEN=0 -> all outputs stay 0; TAKEN_CNT unchanged.
- JAL with BRANCH_TAKEN=0, TARGET=0x200, IMEM_BUSY=1 for 3 cycles -> REDIRECT cycle, then 3 HOLD cycles with PC_SEL=1, FLUSH_IFID=1, FLUSH_IDEX=0, PC_TARGET=0x200; after IMEM_BUSY falls -> IDLE; a branch presented during HOLD is ignored.
- Misaligned BLT target 0x102 -> MISALIGN_EXC=1 for one cycle, MISALIGN_ADDR=0x102, PC_SEL=0, flushes=1, count unchanged; with MISALIGN_CHECK=0 -> normal redirect to 0x102.
- Stall and reset: taken branch with PIPE_STALL=1 for 2 cycles then 0 -> a single redirect and single count. RESET pulled low during HOLD -> outputs 0 immediately, TAKEN_CNT=0, state IDLE.
- Saturation with CNT_W=4: 16 accepted taken branches -> TAKEN_CNT reaches 15 and holds.
